// File: rtl/ro_freq_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : ro_freq_counter_if
// Brief    : Request/result bundle between a requester and ro_freq_counter.
// Revision : 1.0 - initial release
// ============================================================================
interface ro_freq_counter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count_out;
  logic             overflow;

  modport master (
    output start,
    input  busy,
    input  done,
    input  count_out,
    input  overflow
  );

  modport slave (
    input  start,
    output busy,
    output done,
    output count_out,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/ro_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : ro_freq_counter
// Brief    : Gates a ring oscillator and counts its rising edges over a window.
// Revision : 1.0 - initial release
// ============================================================================
module ro_freq_counter #(
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ro_in,
  output logic ro_en,
  ro_freq_counter_if.slave bus
);

  localparam int c_MAX_WS  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int c_TIMER_W = (c_MAX_WS > 1) ? $clog2(c_MAX_WS) : 1;
  localparam logic [c_TIMER_W-1:0] c_SETTLE_LD = c_TIMER_W'(SETTLE - 1);
  localparam logic [c_TIMER_W-1:0] c_WINDOW_LD = c_TIMER_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]     c_CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_s1, r_s2, r_s3;
  logic [c_TIMER_W-1:0]   r_timer, w_timer_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                   r_ovf, w_ovf_nxt, w_ovf_inc;
  logic                   r_ro_en, w_ro_en_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic [CNT_W-1:0]       r_count_out, w_count_out_nxt;
  logic                   r_overflow, w_overflow_nxt;
  logic                   w_rise;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ro_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  // Saturating increment; a rise at full scale flags overflow instead.
  always_comb begin
    w_cnt_inc = r_cnt;
    w_ovf_inc = r_ovf;
    if (w_rise) begin
      if (r_cnt == c_CNT_MAX) begin
        w_ovf_inc = 1'b1;
      end else begin
        w_cnt_inc = r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_done_nxt      = 1'b0;
    w_count_out_nxt = r_count_out;
    w_overflow_nxt  = r_overflow;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SETTLE;
          w_timer_nxt = c_SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (r_timer == '0) begin
          w_state_nxt = S_COUNT;
          w_timer_nxt = c_WINDOW_LD;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_COUNT: begin
        w_cnt_nxt = w_cnt_inc;
        w_ovf_nxt = w_ovf_inc;
        if (r_timer == '0) begin
          // Result includes the final cycle's edge, so publish the incremented value.
          w_state_nxt     = S_DONE;
          w_done_nxt      = 1'b1;
          w_count_out_nxt = w_cnt_inc;
          w_overflow_nxt  = w_ovf_inc;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_ro_en_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_COUNT);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_ro_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count_out <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_ro_en     <= w_ro_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_count_out <= w_count_out_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  assign ro_en         = r_ro_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.count_out = r_count_out;
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ro_freq_counter
// Brief    : Directed bench for ro_freq_counter (16-bit and 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ro_freq_counter;

  localparam int c_S = 4;
  localparam int c_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ro_in = 1'b0;
  logic start = 1'b0;
  logic ro_en16, ro_en4;
  int   ro_period = 0;
  int   ro_phase = 0;
  int   ncnt = 0;

  int total = 0;
  int bad = 0;

  ro_freq_counter_if #(.CNT_W(16)) bus16 ();
  ro_freq_counter_if #(.CNT_W(4))  bus4 ();

  assign bus16.start = start;
  assign bus4.start  = start;

  ro_freq_counter #(.WINDOW(c_W), .SETTLE(c_S), .CNT_W(16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .ro_in (ro_in),
    .ro_en (ro_en16),
    .bus   (bus16.slave)
  );

  ro_freq_counter #(.WINDOW(c_W), .SETTLE(c_S), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .ro_in (ro_in),
    .ro_en (ro_en4),
    .bus   (bus4.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, req, $time);
    end
  endtask

  // Oscillator stand-in, changed only on the falling edge of clk.
  always @(negedge clk) begin
    ncnt++;
    if (ro_period == 0) ro_in = 1'b0;
    else ro_in = (((ncnt + ro_phase) % ro_period) < (ro_period / 2));
  end

  // Model: per-edge ro_in history and a measurement start edge m_t.
  bit   samp [16384];
  int   cyc = 0;
  int   m_t = -1;
  bit   exp_ro_en = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  int   exp_cnt16 = 0, exp_cnt4 = 0;
  bit   exp_ovf16 = 1'b0, exp_ovf4 = 1'b0;

  function automatic bit hist(input int c);
    return samp[c % 16384];
  endfunction

  always @(posedge clk) begin
    int off;
    int sum;
    cyc++;
    samp[cyc % 16384] = rst ? ro_in : 1'b0;
    if (rst) begin
      if (m_t >= 0) begin
        off = cyc - m_t;
        if (off > c_S + c_W) begin
          m_t = -1;
          exp_ro_en = 1'b0;
          exp_busy  = 1'b0;
          exp_done  = 1'b0;
        end else begin
          exp_ro_en = (off < c_S + c_W);
          exp_busy  = 1'b1;
          exp_done  = (off == c_S + c_W);
          if (off == c_S + c_W) begin
            sum = 0;
            for (int c = m_t + c_S; c <= m_t + c_S + c_W - 1; c++)
              sum += int'(hist(c - 1) & ~hist(c - 2));
            exp_cnt16 = (sum > 65535) ? 65535 : sum;
            exp_ovf16 = (sum > 65535);
            exp_cnt4  = (sum > 15) ? 15 : sum;
            exp_ovf4  = (sum > 15);
          end
        end
      end else if (start) begin
        m_t = cyc;
        exp_ro_en = 1'b1;
        exp_busy  = 1'b1;
        exp_done  = 1'b0;
      end else begin
        exp_done = 1'b0;
      end
    end
  end

  always @(negedge rst) begin
    m_t = -1;
    exp_ro_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    exp_cnt16 = 0; exp_cnt4 = 0; exp_ovf16 = 1'b0; exp_ovf4 = 1'b0;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("ro_en16",   32'(ro_en16),         32'(exp_ro_en));
    check("ro_en4",    32'(ro_en4),          32'(exp_ro_en));
    check("busy16",    32'(bus16.busy),      32'(exp_busy));
    check("busy4",     32'(bus4.busy),       32'(exp_busy));
    check("done16",    32'(bus16.done),      32'(exp_done));
    check("done4",     32'(bus4.done),       32'(exp_done));
    check("count16",   32'(bus16.count_out), 32'(exp_cnt16));
    check("count4",    32'(bus4.count_out),  32'(exp_cnt4));
    check("ovf16",     32'(bus16.overflow),  32'(exp_ovf16));
    check("ovf4",      32'(bus4.overflow),   32'(exp_ovf4));
  end

  // Single start pulse; returns negedge index of done plus ro_en/busy cycle tallies.
  task automatic meas(output int n_done, output int n_en, output int n_busy);
    n_done = 0; n_en = 0; n_busy = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (ro_en16) n_en++;
      if (bus16.busy) n_busy++;
      if (bus16.done) begin
        n_done = n;
        break;
      end
    end
    if (n_done == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd, ne, nb, ndone, prev;
    int dt [3];
    logic [15:0] held;

    repeat (3) @(negedge clk);
    check("rst_busy",  32'(bus16.busy),      32'd0);
    check("rst_ro_en", 32'(ro_en16),         32'd0);
    check("rst_count", 32'(bus16.count_out), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Quiet oscillator: timing of ro_en / busy / done.
    ro_period = 0;
    meas(nd, ne, nb);
    check("t1_done_at", 32'(nd), 32'd69);
    check("t1_en_cyc",  32'(ne), 32'd68);
    check("t1_busy_cyc",32'(nb), 32'd69);
    check("t1_count",   32'(bus16.count_out), 32'd0);
    check("t1_ovf",     32'(bus16.overflow),  32'd0);

    ro_period = 4; ro_phase = 1;
    meas(nd, ne, nb);
    check("p4_count16", 32'(bus16.count_out), 32'd16);
    check("p4_count4",  32'(bus4.count_out),  32'd15);
    check("p4_ovf4",    32'(bus4.overflow),   32'd1);

    ro_period = 8; ro_phase = 3;
    meas(nd, ne, nb);
    check("p8_count16", 32'(bus16.count_out), 32'd8);
    check("p8_ovf4",    32'(bus4.overflow),   32'd0);

    ro_period = 2; ro_phase = 0;
    meas(nd, ne, nb);
    check("p2_count16", 32'(bus16.count_out), 32'd32);
    check("p2_count4",  32'(bus4.count_out),  32'd15);
    check("p2_ovf4",    32'(bus4.overflow),   32'd1);

    ro_period = 0;
    meas(nd, ne, nb);
    check("q_count4", 32'(bus4.count_out), 32'd0);
    check("q_ovf4",   32'(bus4.overflow),  32'd0);

    // Start pulses during SETTLE, COUNT and DONE are ignored.
    ro_period = 4; ro_phase = 2;
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 250; n++) begin
      @(negedge clk);
      start = (n == 2) || (n == 30) || (n == 69);
      if (bus16.done) ndone++;
    end
    start = 1'b0;
    check("ign_done_cnt", 32'(ndone), 32'd1);
    check("ign_count16",  32'(bus16.count_out), 32'd16);

    // Held start: back-to-back measurements every SETTLE+WINDOW+2 cycles.
    ro_period = 8; ro_phase = 5;
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 400 && ndone < 3; n++) begin
      @(negedge clk);
      if (bus16.done) begin
        dt[ndone] = n;
        ndone++;
      end
    end
    start = 1'b0;
    check("held_ndone", 32'(ndone), 32'd3);
    if (ndone == 3) begin
      check("held_gap1", 32'(dt[1] - dt[0]), 32'(c_S + c_W + 2));
      check("held_gap2", 32'(dt[2] - dt[1]), 32'(c_S + c_W + 2));
    end
    check("held_count16", 32'(bus16.count_out), 32'd8);
    repeat (3) @(negedge clk);

    // Result holds while the oscillator keeps toggling and start stays low.
    ro_period = 6; ro_phase = 0;
    held = bus16.count_out;
    repeat (100) @(negedge clk);
    check("hold_count16", 32'(bus16.count_out), 32'd8);
    check("hold_same",    32'(bus16.count_out), 32'(held));

    // Asynchronous reset in the middle of COUNT.
    ro_period = 4;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_ro_en", 32'(ro_en16),         32'd0);
    check("arst_busy",  32'(bus16.busy),      32'd0);
    check("arst_done",  32'(bus16.done),      32'd0);
    check("arst_count", 32'(bus16.count_out), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (bus16.done) ndone++;
    end
    check("arst_no_done", 32'(ndone), 32'd0);
    check("arst_idle",    32'(bus16.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
